// File: rtl/led_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph table,
// segment bit positions and the scan state type.
package led_pkg;

  // Segment bit positions within led_segment
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high abcdefg glyphs, indexed by hex nibble (entry 0 is rightmost)
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-high abcdefg glyph.
module hex_to_7seg
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    glyph = GLYPHS[nibble];
  end

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed 3-digit seven-segment driver with anti-ghosting gap,
// brightness control and frame-boundary commit of written values.
// frame_start is high during the last cycle of digit 2's slot, so a write in
// that cycle lands on the commit edge and waits for the following frame.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 2000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [11:0] wr_data,
  input  logic [2:0]  wr_dp,
  input  logic [2:0]  wr_blank,
  input  logic [3:0]  brightness,
  output logic        update_pending,
  output logic        frame_start,
  output logic [7:0]  led_segment,
  output logic [2:0]  led_digit
);

  localparam int CW      = $clog2(DIGIT_CYCLES);
  localparam int ON_STEP = (DIGIT_CYCLES - BLANK_CYCLES) / 16;

  localparam logic [CW-1:0] CNT_LAST       = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST   = CW'(DIGIT_CYCLES - 2);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [2:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  if ((BLANK_CYCLES < 1) || (DIGIT_CYCLES - BLANK_CYCLES <= 0) ||
      ((DIGIT_CYCLES - BLANK_CYCLES) % 16 != 0)) begin : g_bad_params
    $error("led_scan_driver: DIGIT_CYCLES-BLANK_CYCLES must be a nonzero multiple of 16 and BLANK_CYCLES >= 1");
  end

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  scan_state_t   state, state_next;

  logic [11:0] pend_data,  shown_data;
  logic [2:0]  pend_dp,    shown_dp;
  logic [2:0]  pend_blank, shown_blank;

  logic        slot_end, frame_end;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic [31:0] lit_offset, lit_len;
  logic        lit;
  logic [7:0]  seg_next;
  logic [2:0]  dig_next;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd2);

  // Slot counter and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= BLANK;
    else          state <= state_next;
  end

  // Next-state: leave the blank gap when cnt reaches BLANK_CYCLES, return at slot end
  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (cnt == CNT_BLANK_LAST) state_next = SHOW;
      SHOW:    if (slot_end)              state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Pending write capture and frame-boundary commit into the shown value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_data      <= '0;
      pend_dp        <= '0;
      pend_blank     <= '0;
      shown_data     <= '0;
      shown_dp       <= '0;
      shown_blank    <= '0;
      update_pending <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      if (frame_end && update_pending) begin
        shown_data  <= pend_data;
        shown_dp    <= pend_dp;
        shown_blank <= pend_blank;
      end
      if (wr_en) begin
        pend_data      <= wr_data;
        pend_dp        <= wr_dp;
        pend_blank     <= wr_blank;
        update_pending <= 1'b1;
      end else if (frame_end) begin
        update_pending <= 1'b0;
      end
      frame_start <= (idx == 2'd2) && (cnt == CNT_PRE_LAST);
    end
  end

  assign nibble = shown_data[{idx, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Output decode: lit pattern within the brightness window, else off pattern
  always_comb begin
    lit_offset = 32'(cnt) - 32'(BLANK_CYCLES);
    lit_len    = (32'(brightness) + 32'd1) * 32'(ON_STEP);
    lit        = (state == SHOW) && !shown_blank[idx] && (lit_offset < lit_len);
    seg_next   = '0;
    dig_next   = '0;
    if (lit) begin
      seg_next[6:0]    = glyph;
      seg_next[SEG_DP] = shown_dp[idx];
      dig_next         = 3'b001 << idx;
    end
    seg_next = seg_next ^ SEG_OFF;
    dig_next = dig_next ^ DIG_OFF;
  end

  // Registered display pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_segment <= SEG_OFF;
      led_digit   <= DIG_OFF;
    end else begin
      led_segment <= seg_next;
      led_digit   <= dig_next;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver: a timeline model predicts every
// output cycle from the edge count since reset release.
module tb_led_scan_driver;

  localparam int D = 40;
  localparam int B = 8;
  localparam int FRAME = 3 * D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [11:0] wr_data;
  logic [2:0]  wr_dp;
  logic [2:0]  wr_blank;
  logic [3:0]  brightness;
  logic        update_pending;
  logic        frame_start;
  logic [7:0]  led_segment;
  logic [2:0]  led_digit;

  led_scan_driver #(
    .DIGIT_CYCLES   (D),
    .BLANK_CYCLES   (B),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_dp          (wr_dp),
    .wr_blank       (wr_blank),
    .brightness     (brightness),
    .update_pending (update_pending),
    .frame_start    (frame_start),
    .led_segment    (led_segment),
    .led_digit      (led_digit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [2:0] dig;
    logic       up;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  int unsigned k = 0;
  logic [11:0] m_data, m_pdata;
  logic [2:0]  m_dp, m_pdp, m_blank, m_pblank;
  logic        m_pend;

  // Timeline model: position k before each edge decides slot, offset and lit window
  always @(posedge clk) begin
    if (!reset_n) begin
      k = 0;
      m_data = '0; m_dp = '0; m_blank = '0;
      m_pdata = '0; m_pdp = '0; m_pblank = '0;
      m_pend = 1'b0;
      exp_q.delete();
    end else begin
      int slot, off;
      bit on;
      exp_t e;
      logic [7:0] pat;
      slot = int'((k / D) % 3);
      off  = int'(k % D);
      on   = (off >= B) && !m_blank[slot] && ((off - B) < (int'(brightness) + 1) * 2);
      pat  = {m_dp[slot], gly[m_data[slot*4 +: 4]]};
      e.seg = on ? ~pat : 8'hFF;
      e.dig = on ? ~(3'b001 << slot) : 3'b111;
      if ((k % FRAME) == FRAME - 1 && m_pend) begin
        m_data = m_pdata; m_dp = m_pdp; m_blank = m_pblank;
        m_pend = 1'b0;
      end
      if (wr_en) begin
        m_pdata = wr_data; m_pdp = wr_dp; m_pblank = wr_blank;
        m_pend = 1'b1;
      end
      e.up = m_pend;
      e.fs = ((k + 1) % FRAME) == FRAME - 1;
      exp_q.push_back(e);
      k = k + 1;
    end
  end

  // Monitor: every cycle out of reset presents one output vector
  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (led_segment !== e.seg || led_digit !== e.dig ||
          update_pending !== e.up || frame_start !== e.fs) begin
        miscompares++;
        $display("FAIL scan t=%0t got seg=%h dig=%b up=%b fs=%b required seg=%h dig=%b up=%b fs=%b",
                 $time, led_segment, led_digit, update_pending, frame_start,
                 e.seg, e.dig, e.up, e.fs);
      end
    end
  end

  task automatic check_off(input string name);
    vectors++;
    if (led_segment !== 8'hFF || led_digit !== 3'b111 ||
        update_pending !== 1'b0 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL %s got seg=%h dig=%b up=%b fs=%b required seg=ff dig=111 up=0 fs=0",
               name, led_segment, led_digit, update_pending, frame_start);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [11:0] d, input logic [2:0] dp, input logic [2:0] bl);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d; wr_dp = dp; wr_blank = bl;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_fs(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s got no frame_start required pulse within %0d cycles", name, 2 * FRAME);
    end
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0; wr_blank = '0;
    brightness = 4'hF;
    run(3);
    check_off("reset_state");
    #2 reset_n = 1'b1;

    // Power-up frame: digits show 0 at full brightness
    run(FRAME + 10);

    write(12'hA5F, 3'b000, 3'b000);
    run(2 * FRAME);

    brightness = 4'h0;
    run(FRAME);

    // Live brightness changes, including mid-slot
    for (int i = 0; i < 12; i++) begin
      brightness = 4'($urandom_range(0, 15));
      run(int'($urandom_range(3, 20)));
    end

    brightness = 4'hF;
    write(12'h3C7, 3'b010, 3'b100);
    run(2 * FRAME);

    // Write on the frame_start cycle while a value is already pending
    write(12'h123, 3'b000, 3'b000);
    wait_fs("fs_wait", ok);
    if (ok) begin
      wr_en = 1'b1; wr_data = 12'h456; wr_dp = 3'b001; wr_blank = 3'b000;
      @(negedge clk);
      wr_en = 1'b0;
    end
    run(2 * FRAME);

    // Back-to-back writes: last one before the commit wins
    write(12'hBEE, 3'b111, 3'b000);
    write(12'h9D8, 3'b100, 3'b001);
    run(FRAME + 5);

    // Randomized writes and brightness
    for (int i = 0; i < 30; i++) begin
      run(int'($urandom_range(0, 150)));
      brightness = 4'($urandom_range(0, 15));
      write(12'($urandom), 3'($urandom), 3'($urandom_range(0, 7) & 3'($urandom)));
    end
    brightness = 4'hF;
    write(12'hE21, 3'b000, 3'b000);
    run(2 * FRAME);

    // Reset mid-SHOW on digit 1
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (led_digit === 3'b101) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL digit1_wait got no lit digit 1 required within %0d cycles", 2 * FRAME);
    end
    #2 reset_n = 1'b0;
    #1 check_off("reset_mid_show");
    run(3);
    check_off("reset_hold");
    #2 reset_n = 1'b1;
    run(FRAME + 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Time-multiplexed driver for the board's 3-digit seven-segment display: it turns a written 12-bit hex value plus per-digit decimal-point and blank masks into the `led_segment`/`led_digit` pin patterns. It is the output-side counterpart of the button debouncers: it sits inside `system` and drives the display pins, with writes coming from the CPU register bus.
- Anti-ghosting blank gap between digits.
- 4-bit brightness control.
- Tear-free updates committed only at frame boundaries.

## Interface
- DIGIT_CYCLES, 50000: clk cycles per digit slot (1 kHz per slot at 50 MHz).
- BLANK_CYCLES, 2000: cycles at the start of each slot with all digits off.
- SEG_ACTIVE_LOW, 1: 1 means segment pins are driven low when lit.
- DIG_ACTIVE_LOW, 1: 1 means digit pins are driven low when enabled.
- clk  in  1  system clock. One clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  single-cycle write strobe; always accepted, no back-pressure.
- wr_data  in  12  hex value; nibble i is shown on digit i (digit 0 = rightmost).
- wr_dp  in  3  decimal-point enable per digit.
- wr_blank  in  3  per-digit force-off mask.
- brightness  in  4  lit time per slot = (brightness+1)/16 of the non-blank window; sampled live.
- update_pending  out  1  high while a written value awaits commit.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.
- led_segment  out  8  pin pattern, bits 0..6 = segments a..g, bit 7 = dp.
- led_digit  out  3  digit enable pins, one-hot when active.

## Operation
- Registers:
  - pending {data, dp, blank}: loaded on wr_en.
  - shown {data, dp, blank}: the value currently displayed.
  - slot counter cnt: 0..DIGIT_CYCLES-1.
  - digit index idx: 0..2.
- State machine, two states:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW otherwise.
  - BLANK→SHOW when cnt reaches BLANK_CYCLES.
  - SHOW→BLANK when cnt reaches DIGIT_CYCLES-1; cnt then wraps to 0 and idx advances 0→1→2→0.
- Brightness window: ON_STEP = (DIGIT_CYCLES-BLANK_CYCLES)/16. The difference must be a nonzero multiple of 16; elaboration fails otherwise.
- In SHOW, the digit is lit while cnt - BLANK_CYCLES < (brightness+1)*ON_STEP. Otherwise the pins are driven to the off pattern.
- Lit pattern:
  - Segments = hex7 of shown.data nibble idx; dp = shown.dp[idx].
  - led_digit is one-hot on idx.
  - Polarity is applied per SEG_ACTIVE_LOW / DIG_ACTIVE_LOW.
- If shown.blank[idx] is set, the slot produces the off pattern for its full length.
- Commit: on the cycle where idx wraps 2→0, if update_pending is set, pending is copied into shown and update_pending is cleared. frame_start pulses on that same cycle, whether or not a commit happens.
- Write on the commit cycle: the commit uses the pending value registered before that edge. The new write loads pending and update_pending stays 1, so the new value is shown one frame later.
- Back-to-back writes: the last write before the commit wins.
- Reset (asynchronous, any time, mid-slot included):
  - cnt=0, idx=0, state BLANK.
  - shown and pending = 0; update_pending=0; frame_start=0.
  - led_segment and led_digit go to the all-off pattern: 8'hFF / 3'b111 with default parameters.

## Timing
- Outputs are registered and lag cnt/idx by one cycle. There are no combinational paths from inputs to outputs.
- After reset release, the first lit cycle of digit 0 is at edge BLANK_CYCLES+1.
- update_pending rises one edge after wr_en.
- Glyph latency from a write is at most one frame plus one cycle (3*DIGIT_CYCLES+1).
- A brightness change takes effect one cycle later, including mid-slot.
- Hex glyphs, active-high abcdefg order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71

## Structure
- Shared package `led_pkg`:
  - the 16-entry glyph constant table;
  - segment bit-index constants;
  - the state enum {BLANK, SHOW}.
- Sub-module `hex_to_7seg`: 4-bit nibble in, active-high 7-bit glyph out, combinational. It is instanced once on the idx-selected nibble.

## Test plan
Parameters for all scenarios: DIGIT_CYCLES=40, BLANK_CYCLES=8, so ON_STEP=2.
- Reset, then observe: outputs are FF/111 for 9 edges; then digit 0 is lit with glyph for 0 (led_segment=C0, led_digit=110) for 32 cycles.
- Write wr_data=12'hA5F, brightness=15, then run two frames: after the commit, digit0=8E, digit1=92, digit2=88 (active-low), each lit 32 cycles after an 8-cycle gap.
- Set brightness=0: each slot is lit exactly 2 cycles, then off for 30.
- Write with wr_dp=3'b010 and wr_blank=3'b100: digit 1 shows dp (bit7 low); slot 2 stays FF/111 for its full 40 cycles.
- Write exactly on the frame_start cycle: the old value persists one more frame, update_pending stays 1, and the new value appears at the next frame_start.
- Assert reset_n low mid-SHOW on digit 1: outputs are FF/111 immediately; after release, scanning restarts at digit 0 with shown=0.
